// File: rtl/am9513_cai_dispatch.sv
// am9513_cai_dispatch
// CAI submit front-end for the Am9513 accelerator. Validates and decodes
// vendor opcodes and submit flags, tracks a per-context personality, buffers
// accepted commands in a small issue FIFO and keeps per-context sticky IEEE
// exception flags fed by the completion path.
module am9513_cai_dispatch #(
    parameter int DEPTH      = 4,
    parameter int NUM_CTX    = 4,
    parameter int CTX_W      = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1,
    parameter int RESET_MODE = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    // submit path
    input  logic                         sub_valid,
    output logic                         sub_ready,
    input  logic [31:0]                  sub_opcode,
    input  logic [31:0]                  sub_flags,
    input  logic [CTX_W-1:0]             sub_ctx,
    input  logic [7:0]                   sub_tag,
    // issue path
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output logic [7:0]                   iss_func,
    output logic [7:0]                   iss_fmt,
    output logic [7:0]                   iss_src_fmt,
    output logic [2:0]                   iss_mode,
    output logic                         iss_rd_valid,
    output logic [3:0]                   iss_rd,
    output logic [CTX_W-1:0]             iss_ctx,
    output logic [7:0]                   iss_tag,
    // reject report
    output logic                         rej_valid,
    output logic [1:0]                   rej_code,
    output logic [7:0]                   rej_tag,
    // completion and sticky flag access
    input  logic                         cmp_valid,
    input  logic [CTX_W-1:0]             cmp_ctx,
    input  logic [4:0]                   cmp_flags,
    input  logic                         flag_clr_valid,
    input  logic [CTX_W-1:0]             flag_clr_ctx,
    input  logic [4:0]                   flag_clr_mask,
    input  logic [CTX_W-1:0]             flag_rd_ctx,
    output logic [4:0]                   flag_rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   pend_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [7:0] FUNC_CONV = 8'h10;
    localparam logic [2:0] MODE_P2   = 3'd2;
    localparam logic [2:0] MODE_MAX  = 3'd2;

    localparam logic [1:0] REJ_NONE     = 2'd0;
    localparam logic [1:0] REJ_NOT_VEND = 2'd1;
    localparam logic [1:0] REJ_BAD_FUNC = 2'd2;
    localparam logic [1:0] REJ_BAD_MODE = 2'd3;

    // One queued command as it will be presented to the datapath
    typedef struct packed {
        logic [7:0]       func;
        logic [7:0]       fmt;
        logic [7:0]       src_fmt;
        logic [2:0]       mode;
        logic             rd_valid;
        logic [3:0]       rd;
        logic [CTX_W-1:0] ctx;
        logic [7:0]       tag;
    } entry_t;

    // Per-context state
    logic [2:0]       ctx_mode [NUM_CTX];
    logic [4:0]       sticky   [NUM_CTX];

    // Issue queue state
    entry_t           q_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Decode results for the current submit
    logic [7:0]       dec_func;
    logic [7:0]       dec_fmt;
    logic [7:0]       dec_src_fmt;
    logic             func_legal;
    logic             is_conv;
    logic             mode_en;
    logic [2:0]       mode_field;
    logic             mode_bad;
    logic [2:0]       eff_mode;
    logic             needs_p2;
    logic             tier_bad;
    logic [1:0]       dec_code;
    entry_t           new_entry;

    // Handshake qualifiers
    logic             full;
    logic             accept;
    logic             push;
    logic             reject;
    logic             pop;

    // Opcode/flag fields that carry no meaning for this block
    logic             unused_bits;
    assign unused_bits = ^{sub_opcode[30:16], sub_flags[31:12]};

    assign full      = (count == CNT_W'(DEPTH));
    assign sub_ready = !full;
    assign accept    = sub_valid && sub_ready;
    assign push      = accept && (dec_code == REJ_NONE);
    assign reject    = accept && (dec_code != REJ_NONE);
    assign iss_valid = (count != '0);
    assign pop       = iss_valid && iss_ready;

    // Opcode decode, mode resolution, tier gating and reject priority
    always_comb begin
        dec_func    = sub_opcode[7:0];
        dec_fmt     = sub_opcode[15:8];
        func_legal  = ((dec_func >= 8'h01) && (dec_func <= 8'h0A)) ||
                      ((dec_func >= 8'h10) && (dec_func <= 8'h14)) ||
                      ((dec_func >= 8'h20) && (dec_func <= 8'h27));
        is_conv     = (dec_func == FUNC_CONV);
        mode_en     = !is_conv && sub_flags[0];
        mode_field  = sub_flags[3:1];
        mode_bad    = mode_en && (mode_field > MODE_MAX);
        eff_mode    = mode_en ? mode_field : ctx_mode[sub_ctx];
        needs_p2    = ((dec_func >= 8'h06) && (dec_func <= 8'h0A)) ||
                      ((dec_func >= 8'h11) && (dec_func <= 8'h14));
        tier_bad    = needs_p2 && (eff_mode != MODE_P2);
        dec_src_fmt = is_conv ? sub_flags[7:0] : 8'h00;

        if (!sub_opcode[31]) begin
            dec_code = REJ_NOT_VEND;
        end else if (!func_legal) begin
            dec_code = REJ_BAD_FUNC;
        end else if (mode_bad || tier_bad) begin
            dec_code = REJ_BAD_MODE;
        end else begin
            dec_code = REJ_NONE;
        end
    end

    // Assemble the queue entry for an accepted submit
    always_comb begin
        new_entry          = '0;
        new_entry.func     = dec_func;
        new_entry.fmt      = dec_fmt;
        new_entry.src_fmt  = dec_src_fmt;
        new_entry.mode     = eff_mode;
        new_entry.rd_valid = sub_flags[4];
        new_entry.rd       = sub_flags[11:8];
        new_entry.ctx      = sub_ctx;
        new_entry.tag      = sub_tag;
    end

    // Per-context personality: only a successfully enqueued submit may change it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CTX; c++) begin
                ctx_mode[c] <= 3'(RESET_MODE);
            end
        end else if (push && mode_en) begin
            ctx_mode[sub_ctx] <= mode_field;
        end
    end

    // Issue FIFO storage; cleared at reset so the head fields read as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_mem[i] <= '0;
            end
        end else if (push) begin
            q_mem[wr_ptr] <= new_entry;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Registered one-cycle reject report
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rej_valid <= 1'b0;
            rej_code  <= REJ_NONE;
            rej_tag   <= 8'h00;
        end else begin
            rej_valid <= reject;
            if (reject) begin
                rej_code <= dec_code;
                rej_tag  <= sub_tag;
            end
        end
    end

    // Sticky exception flags: clear first, then OR in new completions so set wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CTX; c++) begin
                sticky[c] <= 5'b0;
            end
        end else begin
            for (int c = 0; c < NUM_CTX; c++) begin
                sticky[c] <= (sticky[c] &
                              ~((flag_clr_valid && (flag_clr_ctx == CTX_W'(c))) ? flag_clr_mask : 5'b0)) |
                             ((cmp_valid && (cmp_ctx == CTX_W'(c))) ? cmp_flags : 5'b0);
            end
        end
    end

    assign iss_func     = q_mem[rd_ptr].func;
    assign iss_fmt      = q_mem[rd_ptr].fmt;
    assign iss_src_fmt  = q_mem[rd_ptr].src_fmt;
    assign iss_mode     = q_mem[rd_ptr].mode;
    assign iss_rd_valid = q_mem[rd_ptr].rd_valid;
    assign iss_rd       = q_mem[rd_ptr].rd;
    assign iss_ctx      = q_mem[rd_ptr].ctx;
    assign iss_tag      = q_mem[rd_ptr].tag;

    assign flag_rd_data = sticky[flag_rd_ctx];
    assign pend_count   = count;

endmodule

// File: tb/tb_am9513_cai_dispatch.sv
// tb_am9513_cai_dispatch
// Directed self-checking bench for the CAI dispatch front-end. Inputs are
// driven on the falling edge and outputs are sampled on the falling edge.
module tb_am9513_cai_dispatch;

    localparam int DEPTH   = 4;
    localparam int NUM_CTX = 4;
    localparam int CTX_W   = 2;
    localparam int CNT_W   = 3;

    logic             clk;
    logic             rst_n;
    logic             sub_valid;
    logic             sub_ready;
    logic [31:0]      sub_opcode;
    logic [31:0]      sub_flags;
    logic [CTX_W-1:0] sub_ctx;
    logic [7:0]       sub_tag;
    logic             iss_valid;
    logic             iss_ready;
    logic [7:0]       iss_func;
    logic [7:0]       iss_fmt;
    logic [7:0]       iss_src_fmt;
    logic [2:0]       iss_mode;
    logic             iss_rd_valid;
    logic [3:0]       iss_rd;
    logic [CTX_W-1:0] iss_ctx;
    logic [7:0]       iss_tag;
    logic             rej_valid;
    logic [1:0]       rej_code;
    logic [7:0]       rej_tag;
    logic             cmp_valid;
    logic [CTX_W-1:0] cmp_ctx;
    logic [4:0]       cmp_flags;
    logic             flag_clr_valid;
    logic [CTX_W-1:0] flag_clr_ctx;
    logic [4:0]       flag_clr_mask;
    logic [CTX_W-1:0] flag_rd_ctx;
    logic [4:0]       flag_rd_data;
    logic [CNT_W-1:0] pend_count;

    int errors = 0;
    int checks = 0;

    am9513_cai_dispatch #(
        .DEPTH(DEPTH), .NUM_CTX(NUM_CTX), .CTX_W(CTX_W), .RESET_MODE(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sub_valid(sub_valid), .sub_ready(sub_ready), .sub_opcode(sub_opcode),
        .sub_flags(sub_flags), .sub_ctx(sub_ctx), .sub_tag(sub_tag),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_func(iss_func),
        .iss_fmt(iss_fmt), .iss_src_fmt(iss_src_fmt), .iss_mode(iss_mode),
        .iss_rd_valid(iss_rd_valid), .iss_rd(iss_rd), .iss_ctx(iss_ctx), .iss_tag(iss_tag),
        .rej_valid(rej_valid), .rej_code(rej_code), .rej_tag(rej_tag),
        .cmp_valid(cmp_valid), .cmp_ctx(cmp_ctx), .cmp_flags(cmp_flags),
        .flag_clr_valid(flag_clr_valid), .flag_clr_ctx(flag_clr_ctx), .flag_clr_mask(flag_clr_mask),
        .flag_rd_ctx(flag_rd_ctx), .flag_rd_data(flag_rd_data), .pend_count(pend_count)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one submit for a single cycle; called and returns on a falling edge
    task automatic submit(input logic [31:0] op, input logic [31:0] fl,
                          input logic [CTX_W-1:0] cx, input logic [7:0] tg);
        sub_valid  = 1'b1;
        sub_opcode = op;
        sub_flags  = fl;
        sub_ctx    = cx;
        sub_tag    = tg;
        @(negedge clk);
        sub_valid  = 1'b0;
    endtask

    // Accept the queue head for a single cycle
    task automatic pop_one();
        iss_ready = 1'b1;
        @(negedge clk);
        iss_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (iss_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_iss_valid: got %0h want 0", iss_valid); end
        checks++; if (pend_count !== 3'd0) begin errors++; $display("[TB] FAIL reset_pend: got %0d want 0", pend_count); end
        checks++; if (rej_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rej_valid: got %0h want 0", rej_valid); end
        checks++; if (sub_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_sub_ready: got %0h want 1", sub_ready); end
        checks++; if (iss_func !== 8'h00 || iss_tag !== 8'h00 || rej_code !== 2'd0) begin errors++; $display("[TB] FAIL reset_fields: func=%0h tag=%0h rej_code=%0h want all 0", iss_func, iss_tag, rej_code); end
        for (int c = 0; c < NUM_CTX; c++) begin
            flag_rd_ctx = CTX_W'(c);
            #1;
            checks++; if (flag_rd_data !== 5'h00) begin errors++; $display("[TB] FAIL reset_sticky ctx%0d: got %0h want 0", c, flag_rd_data); end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_issue();
        submit(32'h8000_0301, 32'h0, 2'd0, 8'h11);
        checks++; if (iss_valid !== 1'b1) begin errors++; $display("[TB] FAIL add_valid: got %0h want 1", iss_valid); end
        checks++; if (iss_func !== 8'h01 || iss_fmt !== 8'h03) begin errors++; $display("[TB] FAIL add_decode: func=%0h fmt=%0h want 01/03", iss_func, iss_fmt); end
        checks++; if (iss_mode !== 3'd2 || iss_tag !== 8'h11 || iss_ctx !== 2'd0) begin errors++; $display("[TB] FAIL add_mode_tag: mode=%0d tag=%0h ctx=%0d want 2/11/0", iss_mode, iss_tag, iss_ctx); end
        checks++; if (iss_src_fmt !== 8'h00 || iss_rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_src_rd: src=%0h rdv=%0h want 0/0", iss_src_fmt, iss_rd_valid); end
        checks++; if (pend_count !== 3'd1) begin errors++; $display("[TB] FAIL add_pend: got %0d want 1", pend_count); end
        checks++; if (rej_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_no_reject: got %0h want 0", rej_valid); end
        pop_one();
        checks++; if (pend_count !== 3'd0 || iss_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_drained: pend=%0d valid=%0h want 0/0", pend_count, iss_valid); end
        // explicit result register on ctx 3
        submit(32'h8000_0305, 32'h0000_0510, 2'd3, 8'h22);
        checks++; if (iss_rd_valid !== 1'b1 || iss_rd !== 4'h5 || iss_ctx !== 2'd3 || iss_func !== 8'h05) begin errors++; $display("[TB] FAIL rd_select: rdv=%0h rd=%0h ctx=%0d func=%0h want 1/5/3/05", iss_rd_valid, iss_rd, iss_ctx, iss_func); end
        pop_one();
        // CONV ignores the mode bits (here an out-of-range 3) and carries source format
        submit(32'h8000_0210, 32'h0000_00A7, 2'd0, 8'h33);
        checks++; if (iss_valid !== 1'b1 || rej_valid !== 1'b0) begin errors++; $display("[TB] FAIL conv_accept: valid=%0h rej=%0h want 1/0", iss_valid, rej_valid); end
        checks++; if (iss_src_fmt !== 8'hA7 || iss_fmt !== 8'h02 || iss_func !== 8'h10 || iss_mode !== 3'd2) begin errors++; $display("[TB] FAIL conv_fields: src=%0h fmt=%0h func=%0h mode=%0d want A7/02/10/2", iss_src_fmt, iss_fmt, iss_func, iss_mode); end
        pop_one();
    endtask

    task automatic test_reject();
        submit(32'h0000_0301, 32'h0, 2'd0, 8'h44);
        checks++; if (rej_valid !== 1'b1 || rej_code !== 2'd1 || rej_tag !== 8'h44) begin errors++; $display("[TB] FAIL rej_vendor: v=%0h code=%0d tag=%0h want 1/1/44", rej_valid, rej_code, rej_tag); end
        checks++; if (iss_valid !== 1'b0 || pend_count !== 3'd0) begin errors++; $display("[TB] FAIL rej_vendor_queue: valid=%0h pend=%0d want 0/0", iss_valid, pend_count); end
        @(negedge clk);
        checks++; if (rej_valid !== 1'b0) begin errors++; $display("[TB] FAIL rej_pulse_width: got %0h want 0", rej_valid); end
        submit(32'h8000_03FF, 32'h0, 2'd0, 8'h45);
        checks++; if (rej_valid !== 1'b1 || rej_code !== 2'd2 || rej_tag !== 8'h45) begin errors++; $display("[TB] FAIL rej_func_ff: v=%0h code=%0d tag=%0h want 1/2/45", rej_valid, rej_code, rej_tag); end
        submit(32'h8000_030B, 32'h0, 2'd0, 8'h46);
        checks++; if (rej_valid !== 1'b1 || rej_code !== 2'd2) begin errors++; $display("[TB] FAIL rej_func_0b: v=%0h code=%0d want 1/2", rej_valid, rej_code); end
        submit(32'h8000_0328, 32'h0, 2'd0, 8'h47);
        checks++; if (rej_valid !== 1'b1 || rej_code !== 2'd2) begin errors++; $display("[TB] FAIL rej_func_28: v=%0h code=%0d want 1/2", rej_valid, rej_code); end
        // non-vendor takes priority over unknown func
        submit(32'h0000_03FF, 32'h0, 2'd0, 8'h48);
        checks++; if (rej_code !== 2'd1) begin errors++; $display("[TB] FAIL rej_priority: code=%0d want 1", rej_code); end
        // legal boundary funcs 0A, 14, 27 in P2
        submit(32'h8000_030A, 32'h0, 2'd0, 8'h49);
        checks++; if (rej_valid !== 1'b0 || pend_count !== 3'd1) begin errors++; $display("[TB] FAIL func_0a_ok: rej=%0h pend=%0d want 0/1", rej_valid, pend_count); end
        submit(32'h8000_0314, 32'h0, 2'd0, 8'h4A);
        submit(32'h8000_0327, 32'h0, 2'd0, 8'h4B);
        checks++; if (rej_valid !== 1'b0 || pend_count !== 3'd3) begin errors++; $display("[TB] FAIL func_edges_ok: rej=%0h pend=%0d want 0/3", rej_valid, pend_count); end
        repeat (3) pop_one();
        // mode field value 3 is invalid for a non-CONV op
        submit(32'h8000_0301, 32'h0000_0007, 2'd2, 8'h4C);
        checks++; if (rej_valid !== 1'b1 || rej_code !== 2'd3 || rej_tag !== 8'h4C) begin errors++; $display("[TB] FAIL rej_mode3: v=%0h code=%0d tag=%0h want 1/3/4C", rej_valid, rej_code, rej_tag); end
        checks++; if (pend_count !== 3'd0) begin errors++; $display("[TB] FAIL rej_queue_empty: pend=%0d want 0", pend_count); end
        @(negedge clk);
    endtask

    task automatic test_mode_tier();
        submit(32'h8000_0301, 32'h0000_0003, 2'd1, 8'h51);
        checks++; if (iss_valid !== 1'b1 || iss_mode !== 3'd1 || iss_tag !== 8'h51) begin errors++; $display("[TB] FAIL ctx1_set_p1: valid=%0h mode=%0d tag=%0h want 1/1/51", iss_valid, iss_mode, iss_tag); end
        pop_one();
        submit(32'h8000_0306, 32'h0, 2'd1, 8'h52);
        checks++; if (rej_valid !== 1'b1 || rej_code !== 2'd3 || rej_tag !== 8'h52) begin errors++; $display("[TB] FAIL ctx1_fma_tier: v=%0h code=%0d tag=%0h want 1/3/52", rej_valid, rej_code, rej_tag); end
        checks++; if (iss_valid !== 1'b0) begin errors++; $display("[TB] FAIL ctx1_fma_not_queued: valid=%0h want 0", iss_valid); end
        submit(32'h8000_0306, 32'h0, 2'd0, 8'h53);
        checks++; if (iss_valid !== 1'b1 || iss_mode !== 3'd2 || iss_func !== 8'h06 || rej_valid !== 1'b0) begin errors++; $display("[TB] FAIL ctx0_fma_ok: valid=%0h mode=%0d func=%0h rej=%0h want 1/2/06/0", iss_valid, iss_mode, iss_func, rej_valid); end
        pop_one();
        submit(32'h8000_0320, 32'h0, 2'd1, 8'h54);
        checks++; if (iss_valid !== 1'b1 || iss_mode !== 3'd1) begin errors++; $display("[TB] FAIL ctx1_func20_p1: valid=%0h mode=%0d want 1/1", iss_valid, iss_mode); end
        pop_one();
        submit(32'h8000_0312, 32'h0, 2'd1, 8'h55);
        checks++; if (rej_valid !== 1'b1 || rej_code !== 2'd3) begin errors++; $display("[TB] FAIL ctx1_func12_tier: v=%0h code=%0d want 1/3", rej_valid, rej_code); end
        // inline P2 request on an FMA lifts the tier and updates the context
        submit(32'h8000_0306, 32'h0000_0005, 2'd1, 8'h56);
        checks++; if (iss_valid !== 1'b1 || iss_mode !== 3'd2 || rej_valid !== 1'b0) begin errors++; $display("[TB] FAIL ctx1_fma_inline_p2: valid=%0h mode=%0d rej=%0h want 1/2/0", iss_valid, iss_mode, rej_valid); end
        pop_one();
        submit(32'h8000_0307, 32'h0, 2'd1, 8'h57);
        checks++; if (iss_valid !== 1'b1 || iss_mode !== 3'd2) begin errors++; $display("[TB] FAIL ctx1_cmp_after_p2: valid=%0h mode=%0d want 1/2", iss_valid, iss_mode); end
        pop_one();
        // the earlier rejected mode-3 submit on ctx 2 must not have altered ctx 2
        submit(32'h8000_0306, 32'h0, 2'd2, 8'h58);
        checks++; if (iss_valid !== 1'b1 || iss_mode !== 3'd2 || rej_valid !== 1'b0) begin errors++; $display("[TB] FAIL ctx2_mode_kept: valid=%0h mode=%0d rej=%0h want 1/2/0", iss_valid, iss_mode, rej_valid); end
        pop_one();
    endtask

    task automatic test_back_to_back();
        iss_ready  = 1'b0;
        sub_valid  = 1'b1;
        sub_opcode = 32'h8000_0301;
        sub_flags  = 32'h0;
        sub_ctx    = 2'd0;
        for (int i = 0; i < DEPTH; i++) begin
            sub_tag = 8'h60 + 8'(i);
            @(negedge clk);
        end
        sub_tag = 8'h64;
        checks++; if (sub_ready !== 1'b0 || pend_count !== 3'd4) begin errors++; $display("[TB] FAIL fill_full: ready=%0h pend=%0d want 0/4", sub_ready, pend_count); end
        @(negedge clk);
        checks++; if (pend_count !== 3'd4 || rej_valid !== 1'b0 || iss_tag !== 8'h60) begin errors++; $display("[TB] FAIL full_hold: pend=%0d rej=%0h head=%0h want 4/0/60", pend_count, rej_valid, iss_tag); end
        iss_ready = 1'b1;
        @(negedge clk);
        checks++; if (pend_count !== 3'd3 || iss_tag !== 8'h61 || sub_ready !== 1'b1) begin errors++; $display("[TB] FAIL drain1: pend=%0d head=%0h ready=%0h want 3/61/1", pend_count, iss_tag, sub_ready); end
        @(negedge clk);
        sub_valid = 1'b0;
        checks++; if (pend_count !== 3'd3 || iss_tag !== 8'h62) begin errors++; $display("[TB] FAIL push_pop: pend=%0d head=%0h want 3/62", pend_count, iss_tag); end
        @(negedge clk);
        checks++; if (pend_count !== 3'd2 || iss_tag !== 8'h63) begin errors++; $display("[TB] FAIL drain3: pend=%0d head=%0h want 2/63", pend_count, iss_tag); end
        @(negedge clk);
        checks++; if (pend_count !== 3'd1 || iss_tag !== 8'h64) begin errors++; $display("[TB] FAIL wrap_entry: pend=%0d head=%0h want 1/64", pend_count, iss_tag); end
        @(negedge clk);
        checks++; if (pend_count !== 3'd0 || iss_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty: pend=%0d valid=%0h want 0/0", pend_count, iss_valid); end
        // popping an empty queue is ignored
        @(negedge clk);
        iss_ready = 1'b0;
        checks++; if (pend_count !== 3'd0) begin errors++; $display("[TB] FAIL empty_pop: pend=%0d want 0", pend_count); end
    endtask

    task automatic test_flags();
        flag_rd_ctx = 2'd2;
        cmp_valid = 1'b1; cmp_ctx = 2'd2; cmp_flags = 5'h05;
        @(negedge clk);
        cmp_valid = 1'b0;
        checks++; if (flag_rd_data !== 5'h05) begin errors++; $display("[TB] FAIL sticky_set: got %0h want 05", flag_rd_data); end
        cmp_valid = 1'b1; cmp_ctx = 2'd2; cmp_flags = 5'h10;
        flag_clr_valid = 1'b1; flag_clr_ctx = 2'd2; flag_clr_mask = 5'h1F;
        @(negedge clk);
        cmp_valid = 1'b0; flag_clr_valid = 1'b0;
        checks++; if (flag_rd_data !== 5'h10) begin errors++; $display("[TB] FAIL sticky_clr_set: got %0h want 10", flag_rd_data); end
        cmp_valid = 1'b1; cmp_ctx = 2'd1; cmp_flags = 5'h02;
        flag_clr_valid = 1'b1; flag_clr_ctx = 2'd2; flag_clr_mask = 5'h10;
        @(negedge clk);
        cmp_valid = 1'b0; flag_clr_valid = 1'b0;
        checks++; if (flag_rd_data !== 5'h00) begin errors++; $display("[TB] FAIL sticky_clr_ctx2: got %0h want 00", flag_rd_data); end
        flag_rd_ctx = 2'd1;
        #1;
        checks++; if (flag_rd_data !== 5'h02) begin errors++; $display("[TB] FAIL sticky_set_ctx1: got %0h want 02", flag_rd_data); end
        flag_rd_ctx = 2'd3;
        cmp_valid = 1'b1; cmp_ctx = 2'd3; cmp_flags = 5'h08;
        flag_clr_valid = 1'b1; flag_clr_ctx = 2'd3; flag_clr_mask = 5'h08;
        @(negedge clk);
        cmp_valid = 1'b0; flag_clr_valid = 1'b0;
        checks++; if (flag_rd_data !== 5'h08) begin errors++; $display("[TB] FAIL sticky_set_wins: got %0h want 08", flag_rd_data); end
        cmp_valid = 1'b1; cmp_ctx = 2'd3; cmp_flags = 5'h01;
        @(negedge clk);
        cmp_valid = 1'b0;
        checks++; if (flag_rd_data !== 5'h09) begin errors++; $display("[TB] FAIL sticky_accumulate: got %0h want 09", flag_rd_data); end
    endtask

    task automatic test_reset_midop();
        int rej_seen;
        submit(32'h8000_0301, 32'h0000_0001, 2'd1, 8'h71);
        submit(32'h8000_0302, 32'h0, 2'd0, 8'h72);
        submit(32'h8000_0303, 32'h0, 2'd0, 8'h73);
        cmp_valid = 1'b1; cmp_ctx = 2'd0; cmp_flags = 5'h1F;
        @(negedge clk);
        cmp_valid = 1'b0;
        checks++; if (pend_count !== 3'd3) begin errors++; $display("[TB] FAIL midop_prefill: pend=%0d want 3", pend_count); end
        #2;
        rst_n = 1'b0;
        #1;
        flag_rd_ctx = 2'd0;
        #1;
        checks++; if (iss_valid !== 1'b0 || pend_count !== 3'd0) begin errors++; $display("[TB] FAIL midop_async_clear: valid=%0h pend=%0d want 0/0", iss_valid, pend_count); end
        checks++; if (flag_rd_data !== 5'h00) begin errors++; $display("[TB] FAIL midop_sticky: got %0h want 00", flag_rd_data); end
        rej_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (rej_valid !== 1'b0) rej_seen++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (rej_valid !== 1'b0) rej_seen++;
        checks++; if (rej_seen !== 0) begin errors++; $display("[TB] FAIL midop_no_reject: pulses=%0d want 0", rej_seen); end
        // ctx 1 had been switched to P0; reset restores P2 so FMA is accepted
        submit(32'h8000_0306, 32'h0, 2'd1, 8'h74);
        checks++; if (iss_valid !== 1'b1 || iss_mode !== 3'd2 || iss_tag !== 8'h74 || rej_valid !== 1'b0) begin errors++; $display("[TB] FAIL midop_mode_restored: valid=%0h mode=%0d tag=%0h rej=%0h want 1/2/74/0", iss_valid, iss_mode, iss_tag, rej_valid); end
        pop_one();
    endtask

    // Test sequence
    initial begin
        rst_n = 1'b0;
        sub_valid = 1'b0; sub_opcode = 32'h0; sub_flags = 32'h0; sub_ctx = '0; sub_tag = 8'h0;
        iss_ready = 1'b0;
        cmp_valid = 1'b0; cmp_ctx = '0; cmp_flags = 5'h0;
        flag_clr_valid = 1'b0; flag_clr_ctx = '0; flag_clr_mask = 5'h0;
        flag_rd_ctx = '0;
        @(negedge clk);
        test_reset();
        test_basic_issue();
        test_reject();
        test_mode_tier();
        test_back_to_back();
        test_flags();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
